mips_prog_loader: RTL and testbench
===================================

MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
- REQ-001 SHALL have parameter ADDR_W, default 10, the width of the instruction-memory word address.
- REQ-002 SHALL have parameter MAX_WORDS, default 1024, the maximum program length in words.
- REQ-003 SHALL have port clk1, input, 1: the single clock; every register updates on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
- REQ-005 SHALL have port load_en, input, 1: one-cycle pulse that starts a load.
- REQ-006 SHALL have port in_data, input, 8: boot byte stream.
- REQ-007 SHALL have port in_valid, input, 1: in_data is valid.
- REQ-008 SHALL have port in_ready, output, 1: the loader accepts the current byte.
- REQ-009 SHALL have port mem_we, output, 1: write strobe to the core instruction memory.
- REQ-010 SHALL have port mem_addr, output, ADDR_W: word address of the write.
- REQ-011 SHALL have port mem_wdata, output, 32: instruction word to write.
- REQ-012 SHALL have port core_hold, output, 1: holds the core halted (drives its HALTED flag).
- REQ-013 SHALL have port core_start, output, 1: one-cycle pulse that clears the core PC to 0 and releases it.
- REQ-014 SHALL have ports busy, done, err, each output, 1: status flags.

Function
- REQ-015 SHALL use states IDLE, HDR, DATA, CHK, START, DONE and ERR.
- REQ-016 SHALL accept a byte only when in_valid and in_ready are both high in the same cycle.
- REQ-017 SHALL hold in_ready high in HDR, DATA and CHK only, and low in every other state.
- REQ-018 SHALL, on load_en in IDLE, DONE or ERR: go to HDR, set core_hold=1, clear done and err, and clear the byte, word and checksum counters.
- REQ-019 SHALL ignore load_en in HDR, DATA, CHK and START.
- REQ-020 SHALL assemble bytes big-endian: first accepted byte goes to bits [31:24], fourth to [7:0].
- REQ-021 SHALL treat the first word as the word count N.
- REQ-022 SHALL, for N=0, go to CHK if LOADER_CHECKSUM_EN is defined, otherwise to START.
- REQ-023 SHALL, for N>MAX_WORDS, go to ERR without issuing any memory write.
- REQ-024 SHALL, otherwise, go to DATA.
- REQ-025 SHALL, in DATA, pulse mem_we for exactly one cycle, in the cycle after the 4th byte handshake of each word.
- REQ-026 SHALL drive mem_addr = word index (0..N-1) and mem_wdata = the assembled word with each mem_we pulse.
- REQ-027 SHALL keep accepting the next byte in the same cycle that mem_we is high, with no bubble.
- REQ-028 SHALL, after the write of word N-1, go to CHK if LOADER_CHECKSUM_EN is defined, otherwise to START.
- REQ-029 SHALL, in START, assert core_start for one cycle and drop core_hold, then go to DONE.
- REQ-030 SHALL, in DONE, hold done=1 and core_hold=0.
- REQ-031 SHALL, in ERR, hold err=1 and core_hold=1, and never assert core_start.
- REQ-032 SHALL set busy=1 in HDR, DATA, CHK and START, and busy=0 otherwise.
- REQ-033 SHALL allow in_valid gaps of any length between bytes without changing the result.
- REQ-034 SHALL hold mem_we low outside DATA.

Reset
- REQ-035 SHALL, with rst_n=0 at a clk1 edge, go to IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, core_start=0, busy=0, done=0 and err=0.
- REQ-036 SHALL, on reset mid-load, abandon the partial word, issue no further writes and not pulse core_start.

Configuration
- REQ-037 SHALL, when LOADER_CHECKSUM_EN is defined, keep a running XOR of all accepted bytes (header included), accept one trailer byte in CHK, go to START if it equals the XOR, and go to ERR otherwise.
- REQ-038 SHALL, when LOADER_CHECKSUM_EN is not defined, contain no CHK state logic or checksum register, and treat the stream as header plus data only.

Verification
- REQ-039 SHALL check reset: rst_n low for 2 cycles -> all outputs at the REQ-035 values.
- REQ-040 SHALL check a normal load: load_en, then bytes 00 00 00 02 28 01 00 0a fc 00 00 00 (plus DD with the macro) -> writes (0, 2801000a) and (1, fc000000), one core_start pulse, done=1, core_hold=0.
- REQ-041 SHALL check the same stream with random 0-5 cycle in_valid gaps -> identical writes and core_start.
- REQ-042 SHALL check N=0 (00 00 00 00, plus 00 with the macro) -> no mem_we, core_start pulse, done=1.
- REQ-043 SHALL check N=MAX_WORDS+1 -> err=1, no mem_we, core_hold=1, no core_start.
- REQ-044 SHALL check, with the macro, the REQ-040 stream with trailer 00 -> err=1 and no core_start; and check rst_n pulsed after byte 6 -> IDLE with no further writes.

Source files
------------

// File: rtl/mips_prog_loader.sv
// Boot loader: streams a length-prefixed big-endian image into instruction memory, then starts the core.
// Define LOADER_CHECKSUM_EN to require an XOR trailer byte (CHK state) before the core is started.
module mips_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, CHK, START, DONE, ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t POST_DATA = CHK;
`else
    localparam state_t POST_DATA = START;
`endif

    state_t state_q, state_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [23:0] shift_q, shift_d;
    logic in_ready_q, in_ready_d;
    logic mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic core_hold_q, core_hold_d;
    logic core_start_q, core_start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic accept;
    logic last_byte;
    logic [31:0] word;

    assign accept    = in_valid && in_ready_q;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    assign word      = {shift_q, in_data};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        n_d         = n_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        if (accept) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], in_data};
`ifdef LOADER_CHECKSUM_EN
            csum_d     = csum_q ^ in_data;
`endif
        end

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (load_en) begin
                    state_d    = HDR;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            HDR: begin
                if (last_byte) begin
                    if (word == 32'd0) begin
                        state_d = POST_DATA;
                    end else if (word > 32'(MAX_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                        n_d     = CNT_W'(word);
                    end
                end
            end
            DATA: begin
                if (last_byte) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(word_cnt_q);
                    mem_wdata_d = word;
                    word_cnt_d  = word_cnt_q + CNT_W'(1);
                    // The strobe for the last word lands in the first post-DATA cycle.
                    if (word_cnt_d == n_q) begin
                        state_d = POST_DATA;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? START : ERR;
                end
            end
`endif
            START: state_d = DONE;
            default: state_d = state_q;
        endcase

        in_ready_d   = state_d inside {HDR, DATA, CHK};
        busy_d       = state_d inside {HDR, DATA, CHK, START};
        core_start_d = (state_d == START);
        core_hold_d  = !(state_d inside {START, DONE});
        done_d       = (state_d == DONE);
        err_d        = (state_d == ERR);
    end

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            n_q          <= '0;
            shift_q      <= '0;
            in_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_hold_q  <= 1'b1;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_hold_q  <= core_hold_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_hold  = core_hold_q;
    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: byte streams with random gaps checked against a stream-level model.
// Honours LOADER_CHECKSUM_EN the same way as the design (trailer byte appended when defined).
module tb_mips_prog_loader;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [ADDR_W+31:0] wr_t;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              load_en;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              core_start;
    logic              busy;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;
    wr_t wq[$];
    int starts = 0;

    mips_prog_loader #(
        .ADDR_W(ADDR_W),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk1(clk1),
        .rst_n(rst_n),
        .load_en(load_en),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .core_start(core_start),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk1 = ~clk1;

    // Every negedge with a strobe high is one observed write / start pulse.
    always @(negedge clk1) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (core_start) starts++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; !in_ready; t++) begin
            if (t >= 50) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk1);
        end
        @(negedge clk1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_en = 1'b1;
        @(negedge clk1);
        load_en = 1'b0;
    endtask

    task automatic run_load(input byte_q_t s, input int max_gap, input bit poke);
        int   wb;
        int   sb;
        int   n;
        bit   ok;
        wr_t  ew[$];
        logic [31:0] hdr;
        logic [7:0]  x;
        wb = wq.size();
        sb = starts;
        @(negedge clk1);
        pulse_load();
        foreach (s[i]) begin
            send_byte(s[i], $urandom_range(max_gap, 0));
            if (poke && i == 5) pulse_load();
        end
        repeat (8) @(negedge clk1);

        hdr = {s[0], s[1], s[2], s[3]};
        ok  = 1'b1;
        if (hdr > 32'(MAX_WORDS)) begin
            ok = 1'b0;
        end else begin
            n = int'(hdr);
            for (int i = 0; i < n; i++)
                ew.push_back({ADDR_W'(i), s[4+4*i], s[5+4*i], s[6+4*i], s[7+4*i]});
`ifdef LOADER_CHECKSUM_EN
            x = 8'h00;
            for (int i = 0; i < 4 + 4 * n; i++) x ^= s[i];
            ok = (s[4+4*n] == x);
`else
            x = 8'h00;
`endif
        end

        vectors++;
        if (wq.size() - wb !== ew.size()) begin
            miscompares++;
            $display("FAIL write_count: got %0d required %0d", wq.size() - wb, ew.size());
        end else begin
            for (int i = 0; i < ew.size(); i++) begin
                vectors++;
                if (wq[wb+i] !== ew[i]) begin
                    miscompares++;
                    $display("FAIL write[%0d]: got %h required %h", i, wq[wb+i], ew[i]);
                end
            end
        end
        vectors++;
        if (starts - sb !== (ok ? 1 : 0)) begin
            miscompares++;
            $display("FAIL core_start_pulses: got %0d required %0d", starts - sb, ok ? 1 : 0);
        end
        vectors++;
        if ({done, err, core_hold, busy, in_ready} !== {ok, !ok, !ok, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL status done/err/hold/busy/rdy: got %b required %b",
                     {done, err, core_hold, busy, in_ready}, {ok, !ok, !ok, 1'b0, 1'b0});
        end
    endtask

    function automatic byte_q_t make_stream(input int n, input bit rnd, input bit bad_sum);
        byte_q_t s;
        logic [31:0] w;
        logic [7:0] x;
        s = '{};
        w = n;
        for (int k = 3; k >= 0; k--) s.push_back(w[8*k +: 8]);
        for (int i = 0; i < n; i++) begin
            w = rnd ? $urandom : i * 32'h01010101;
            for (int k = 3; k >= 0; k--) s.push_back(w[8*k +: 8]);
        end
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (s[i]) x ^= s[i];
        s.push_back(bad_sum ? ~x : x);
`else
        x = {7'd0, bad_sum};
`endif
        return s;
    endfunction

    function automatic byte_q_t ref_stream();
        byte_q_t s;
        s = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0a,
              8'hfc, 8'h00, 8'h00, 8'h00};
        return s;
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        load_en  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk1);
        vectors++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, core_hold, core_start, busy, done, err}
            !== {1'b0, 1'b0, {ADDR_W{1'b0}}, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h wd=%h hold=%b start=%b busy=%b done=%b err=%b required 0 0 0 0 1 0 0 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, core_hold, core_start, busy, done, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal(input int max_gap);
        byte_q_t s;
        s = ref_stream();
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'hDD);
`endif
        run_load(s, max_gap, 1'b0);
    endtask

    task automatic test_zero_words();
        run_load(make_stream(0, 1'b0, 1'b0), 2, 1'b0);
    endtask

    task automatic test_too_big();
        byte_q_t s;
        logic [31:0] n;
        n = MAX_WORDS + 1;
        s = '{n[31:24], n[23:16], n[15:8], n[7:0]};
        run_load(s, 3, 1'b0);
    endtask

    task automatic test_max_words();
        run_load(make_stream(MAX_WORDS, 1'b0, 1'b0), 0, 1'b0);
    endtask

    task automatic test_ignore_load();
        run_load(make_stream(3, 1'b1, 1'b0), 2, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++)
            run_load(make_stream($urandom_range(6, 1), 1'b1, ($urandom_range(3, 0) == 0)),
                     $urandom_range(5, 0), 1'b0);
    endtask

    task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
        byte_q_t s;
        s = ref_stream();
        s.push_back(8'h00);
        run_load(s, 1, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        byte_q_t s;
        int wb;
        int sb;
        s  = ref_stream();
        wb = wq.size();
        sb = starts;
        @(negedge clk1);
        pulse_load();
        for (int i = 0; i < 6; i++) send_byte(s[i], 1);
        rst_n = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk1);
        vectors++;
        if (wq.size() - wb !== 0 || starts - sb !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_activity: writes=%0d starts=%0d required 0 0",
                     wq.size() - wb, starts - sb);
        end
        vectors++;
        if ({in_ready, busy, core_hold, done, err} !== 5'b00100) begin
            miscompares++;
            $display("FAIL reset_mid_state: rdy/busy/hold/done/err=%b required 00100",
                     {in_ready, busy, core_hold, done, err});
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal(0);
        test_normal(5);
        test_zero_words();
        test_too_big();
        test_normal(0);
        test_bad_checksum();
        test_ignore_load();
        test_random();
        test_max_words();
        test_reset_mid();
        test_normal(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
